// File: rtl/mem_stage_if.sv
// Bus bundle between the memory-access stage and its neighbours.
// The slave modport is the stage itself; master is whoever drives the execute bus and the SRAM read data.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70
);
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [37:0]             mem_to_id_bus;
  logic                    mem_addr_err;

  modport master (
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id_bus,
    input  mem_addr_err
  );

  modport slave (
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id_bus,
    output mem_addr_err
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: registers the execute bus, aligns/extends load data and
// produces the write-back and decode-forwarding buses; a one-word buffer keeps load data across stalls.
module mem_stage #(
  parameter int StallBus = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallBus-1:0] stall,
  mem_stage_if.slave          bus_if,
  // Debug tap: {stall, fresh, carried data_ram_wen}
  output logic [10:0]         dbg
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [78:0] bus_q, bus_d;
  logic        fresh_q, fresh_d;
  logic [31:0] rdata_h_q, rdata_h_d;

  // A bubble counts as a new occupant, so it is fresh just like a real capture.
  always_comb begin
    bus_d     = bus_q;
    fresh_d   = 1'b0;
    rdata_h_d = rdata_h_q;
    if (stall[3] && !stall[4]) begin
      bus_d   = '0;
      fresh_d = 1'b1;
    end else if (!stall[3]) begin
      bus_d   = bus_if.ex_to_mem_bus;
      fresh_d = 1'b1;
    end
    if (fresh_q) begin
      rdata_h_d = bus_if.data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q     <= '0;
      fresh_q   <= 1'b0;
      rdata_h_q <= '0;
    end else begin
      bus_q     <= bus_d;
      fresh_q   <= fresh_d;
      rdata_h_q <= rdata_h_d;
    end
  end

  logic [31:0] mem_pc;
  logic [2:0]  mem_op;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  a;

  assign mem_pc       = bus_q[78:47];
  assign mem_op       = bus_q[46:44];
  assign data_ram_en  = bus_q[43];
  assign data_ram_wen = bus_q[42:39];
  assign sel_rf_res   = bus_q[38];
  assign rf_we        = bus_q[37];
  assign rf_waddr     = bus_q[36:32];
  assign ex_result    = bus_q[31:0];
  assign a            = ex_result[1:0];

  // SRAM data is only valid live in the fresh cycle; afterwards the held copy stands in.
  logic [31:0] rd;
  assign rd = fresh_q ? bus_if.data_sram_rdata : rdata_h_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rd[7:0];
    case (a)
      2'd0: ld_byte = rd[7:0];
      2'd1: ld_byte = rd[15:8];
      2'd2: ld_byte = rd[23:16];
      2'd3: ld_byte = rd[31:24];
      default: ld_byte = rd[7:0];
    endcase
  end

  // Halfword selection ignores a[0]; a misaligned halfword is flagged but uses the aligned-down half.
  assign ld_half = a[1] ? rd[31:16] : rd[15:0];

  logic [31:0] load_data;

  always_comb begin
    load_data = 32'h0;
    case (mem_op)
      OP_LW:   load_data = rd;
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase
  end

  logic [31:0] rf_wdata;
  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  logic word_mis;
  logic half_mis;
  assign word_mis = (mem_op == OP_LW) && (a != 2'd0);
  assign half_mis = ((mem_op == OP_LH) || (mem_op == OP_LHU)) && a[0];

  assign bus_if.mem_addr_err  = data_ram_en && (word_mis || half_mis);
  assign bus_if.mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
  assign bus_if.mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

  assign dbg = {stall[5:0], fresh_q, data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-occupant reference model plus directed literal checks and random traffic.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic [10:0] dbg;

  mem_stage_if u_if ();

  mem_stage dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .bus_if (u_if),
    .dbg    (dbg)
  );

  always #10 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: the instruction currently in the stage, whether this is its first cycle,
  // and the SRAM word it saw in that first cycle.
  logic [78:0] occ       = '0;
  logic        occ_first = 1'b0;
  logic [31:0] occ_word  = '0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                     input logic en, input logic sel, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] res);
    return {pc, op, en, 4'b0000, sel, we, waddr, res};
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [78:0] b, input logic [31:0] word);
    int a;
    int bv;
    int hv;
    a  = int'(b[1:0]);
    bv = int'((word >> (8 * a)) & 32'hFF);
    hv = int'((word >> (16 * (a / 2))) & 32'hFFFF);
    if (!b[38]) return b[31:0];
    case (b[46:44])
      3'd0:    return word;
      3'd1:    return (bv >= 128) ? 32'(bv - 256) : 32'(bv);
      3'd2:    return 32'(bv);
      3'd3:    return (hv >= 32768) ? 32'(hv - 65536) : 32'(hv);
      3'd4:    return 32'(hv);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [78:0] b);
    int a;
    int op;
    a  = int'(b[1:0]);
    op = int'(b[46:44]);
    return b[43] && (((op == 0) && (a != 0)) || (((op == 3) || (op == 4)) && ((a % 2) == 1)));
  endfunction

  // Occupancy model: what sits in the stage after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= '0;
      occ_first <= 1'b0;
    end else if (stall[3] && stall[4]) begin
      occ_first <= 1'b0;
    end else begin
      occ       <= stall[3] ? 79'h0 : u_if.ex_to_mem_bus;
      occ_first <= 1'b1;
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    check("wb_bus", u_if.mem_to_wb_bus,
          {occ[78:47], occ[37], occ[36:32],
           exp_wdata(occ, occ_first ? u_if.data_sram_rdata : occ_word)});
    check("id_bus", {32'h0, u_if.mem_to_id_bus},
          {32'h0, occ[37], occ[36:32],
           exp_wdata(occ, occ_first ? u_if.data_sram_rdata : occ_word)});
    check("addr_err", {69'h0, u_if.mem_addr_err}, {69'h0, exp_err(occ)});
    check("fresh", {69'h0, dbg[4]}, {69'h0, occ_first});
    if (occ_first) occ_word <= u_if.data_sram_rdata;
  end

  // Inputs for one cycle: rd is the SRAM data seen by the current occupant,
  // b/st are sampled at the next edge. Returns mid-cycle, after outputs settle.
  task automatic cyc(input logic [78:0] b, input logic [5:0] st, input logic [31:0] rd);
    @(posedge clk);
    #1;
    u_if.ex_to_mem_bus   = b;
    stall                = st;
    u_if.data_sram_rdata = rd;
    @(negedge clk);
    #1;
  endtask

  logic [78:0] nop;
  logic [78:0] rb;
  logic [5:0]  rs;

  initial begin
    u_if.ex_to_mem_bus   = '0;
    u_if.data_sram_rdata = '0;
    nop = mk(32'h0, 3'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    #1 rst = 1'b1;
    #2;
    check("rst_wb", u_if.mem_to_wb_bus, 70'h0);
    check("rst_id", {32'h0, u_if.mem_to_id_bus}, 70'h0);
    check("rst_err", {69'h0, u_if.mem_addr_err}, 70'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // LW, fresh data used live
    cyc(mk(32'h400, 3'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1000), 6'h0, 32'h0);
    cyc(nop, 6'h0, 32'hDEADBEEF);
    check("lw_wb", u_if.mem_to_wb_bus, {32'h400, 1'b1, 5'd5, 32'hDEADBEEF});
    check("lw_id", {32'h0, u_if.mem_to_id_bus}, {32'h0, 1'b1, 5'd5, 32'hDEADBEEF});
    check("lw_err", {69'h0, u_if.mem_addr_err}, 70'h0);

    // Byte / halfword extension
    cyc(mk(32'h404, 3'd1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1003), 6'h0, 32'h0);
    cyc(mk(32'h408, 3'd2, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1003), 6'h0, 32'h80123456);
    check("lb", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'hFFFFFF80});
    cyc(mk(32'h40C, 3'd3, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1002), 6'h0, 32'h80123456);
    check("lbu", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'h00000080});
    cyc(mk(32'h410, 3'd4, 1'b1, 1'b1, 1'b1, 5'd6, 32'h1002), 6'h0, 32'h80123456);
    check("lh", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'hFFFF8012});
    cyc(nop, 6'h0, 32'h80123456);
    check("lhu", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'h00008012});

    // Stall hold: value must stay bit-identical while SRAM data changes
    cyc(mk(32'h500, 3'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h2000), 6'h0, 32'h0);
    cyc(nop, 6'b011000, 32'hCAFEF00D);
    check("hold0", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFEF00D});
    cyc(nop, 6'b011000, 32'h0);
    check("hold1", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFEF00D});
    cyc(nop, 6'b011000, 32'h0);
    check("hold2", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFEF00D});
    cyc(nop, 6'h0, 32'h0);
    check("hold3", {38'h0, u_if.mem_to_id_bus[31:0]}, {38'h0, 32'hCAFEF00D});

    // Bubble, then ALU result and misaligned LW
    cyc(mk(32'h600, 3'd0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h3000), 6'b001000, 32'h0);
    cyc(mk(32'h604, 3'd7, 1'b0, 1'b0, 1'b1, 5'd9, 32'h00000042), 6'h0, 32'h55AA55AA);
    check("bubble_wb", u_if.mem_to_wb_bus, 70'h0);
    check("bubble_id", {32'h0, u_if.mem_to_id_bus}, 70'h0);
    cyc(mk(32'h608, 3'd0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h00001002), 6'h0, $urandom);
    check("alu_wdata", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'h00000042});
    cyc(nop, 6'h0, $urandom);
    check("lw_mis_err", {69'h0, u_if.mem_addr_err}, {69'h0, 1'b1});

    // Asynchronous reset mid-stall
    cyc(mk(32'h700, 3'd0, 1'b1, 1'b1, 1'b1, 5'd11, 32'h4000), 6'h0, 32'h0);
    cyc(nop, 6'b011000, 32'h11112222);
    #3 rst = 1'b1;
    #1;
    check("arst_wb", u_if.mem_to_wb_bus, 70'h0);
    check("arst_id", {32'h0, u_if.mem_to_id_bus}, 70'h0);
    check("arst_err", {69'h0, u_if.mem_addr_err}, 70'h0);
    #2 rst = 1'b0;
    cyc(mk(32'h800, 3'd0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h5000), 6'h0, 32'h0);
    cyc(nop, 6'h0, 32'h12345678);
    check("post_rst_lw", {38'h0, u_if.mem_to_wb_bus[31:0]}, {38'h0, 32'h12345678});

    // Random traffic against the model
    repeat (400) begin
      rb = mk($urandom, 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom);
      rb[42:39] = 4'($urandom_range(0, 15));
      rs = 6'($urandom_range(0, 63));
      rs[3] = ($urandom_range(0, 2) == 0);
      rs[4] = ($urandom_range(0, 2) == 0);
      cyc(rb, rs, $urandom);
    end

    cyc(nop, 6'h0, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
